oric_tap_player: RTL

Cassette-signal synthesiser for the Oric core. It takes a stream of tape-image bytes over a valid/ready handshake, for example from an SDRAM port2 reader. It serialises each byte into the Oric fast-format waveform (start bit, 8 data bits LSB first, odd parity, stop bits) and drives the result onto the core's K7_TAPEIN input in place of the UART_RXD line. The core's K7_REMOTE (motor relay) gates playback.

---
 rtl/oric_tap_player.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/oric_tap_player.sv
// Oric fast-format cassette synthesiser: serialises tape bytes into start, data (LSB first),
// odd parity and stop cells on tape_out, with playback gated by the K7_REMOTE motor line.
module oric_tap_player #(
   parameter int T_UNIT    = 4992,
   parameter int STOP_BITS = 4
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        remote,
   output logic        tape_out,
   output logic        busy,
   output logic [15:0] bytes_sent
);

   localparam int            CW          = $clog2(2 * T_UNIT);
   localparam logic [CW-1:0] C_T1        = CW'(T_UNIT - 1);
   localparam logic [CW-1:0] C_T2        = CW'(2 * T_UNIT - 1);
   localparam logic [2:0]    C_STOP_LAST = 3'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~(^d);
   endfunction

   state_t        r_state, w_state_n, w_cur_state;
   logic [2:0]    r_bitcnt, w_bitcnt_n, w_next_idx;
   logic [7:0]    r_shift, w_shift_n;
   logic [7:0]    r_hold, w_hold_n;
   logic          r_full, w_full_n;
   logic          r_silent, w_silent_n;
   logic          r_low, w_low_n;
   logic          r_bit, w_bit_n;
   logic          r_tape, w_tape_n;
   logic          r_busy, w_busy_n;
   logic [CW-1:0] r_cnt, w_cnt_n;
   logic [15:0]   r_sent, w_sent_n;
   logic          w_cell_end, w_boundary, w_frame_done;

   assign in_ready   = ~r_full;
   assign tape_out   = r_tape;
   assign busy       = r_busy;
   assign bytes_sent = r_sent;

   // A cell ends when its LOW phase expires; while silent every clock is a decision point.
   assign w_cell_end   = ~r_silent & r_low & (r_cnt == (r_bit ? C_T1 : C_T2));
   assign w_boundary   = r_silent | w_cell_end;
   assign w_frame_done = w_cell_end & (r_state == S_STOP) & (r_bitcnt == C_STOP_LAST);
   assign w_cur_state  = w_frame_done ? S_IDLE : r_state;
   assign w_next_idx   = r_bitcnt + 3'd1;

   // Next-state: holding register, frame sequencing and cell phase timing.
   always_comb begin
      w_state_n  = r_state;
      w_bitcnt_n = r_bitcnt;
      w_shift_n  = r_shift;
      w_hold_n   = r_hold;
      w_full_n   = r_full;
      w_silent_n = r_silent;
      w_low_n    = r_low;
      w_bit_n    = r_bit;
      w_tape_n   = r_tape;
      w_busy_n   = r_busy;
      w_sent_n   = r_sent;
      w_cnt_n    = r_cnt + CW'(1);

      if (in_valid && !r_full) begin
         w_hold_n = in_data;
         w_full_n = 1'b1;
      end else begin
         w_hold_n = r_hold;
      end

      if (w_frame_done) begin
         w_sent_n  = r_sent + 16'd1;
         w_busy_n  = 1'b0;
         w_state_n = S_IDLE;
      end else begin
         w_sent_n = r_sent;
      end

      if (w_boundary) begin
         if (!remote) begin
            w_silent_n = 1'b1;
            w_tape_n   = 1'b0;
            w_cnt_n    = {CW{1'b0}};
         end else begin
            w_silent_n = 1'b0;
            w_low_n    = 1'b0;
            w_tape_n   = 1'b1;
            w_cnt_n    = {CW{1'b0}};
            case (w_cur_state)
               S_IDLE: begin
                  if (r_full) begin
                     w_shift_n = r_hold;
                     w_full_n  = 1'b0;
                     w_state_n = S_START;
                     w_bit_n   = 1'b0;
                     w_busy_n  = 1'b1;
                  end else begin
                     w_state_n = S_IDLE;
                     w_bit_n   = 1'b1;
                  end
               end
               S_START: begin
                  w_state_n  = S_DATA;
                  w_bitcnt_n = 3'd0;
                  w_bit_n    = r_shift[0];
               end
               S_DATA: begin
                  if (r_bitcnt == 3'd7) begin
                     w_state_n = S_PARITY;
                     w_bit_n   = odd_parity(r_shift);
                  end else begin
                     w_bitcnt_n = w_next_idx;
                     w_bit_n    = r_shift[w_next_idx];
                  end
               end
               S_PARITY: begin
                  w_state_n  = S_STOP;
                  w_bitcnt_n = 3'd0;
                  w_bit_n    = 1'b1;
               end
               S_STOP: begin
                  w_bitcnt_n = w_next_idx;
                  w_bit_n    = 1'b1;
               end
               default: begin
                  w_state_n = S_IDLE;
                  w_bit_n   = 1'b1;
               end
            endcase
         end
      end else if (!r_low && (r_cnt == C_T1)) begin
         w_low_n  = 1'b1;
         w_tape_n = 1'b0;
         w_cnt_n  = {CW{1'b0}};
      end else begin
         w_low_n = r_low;
      end
   end

   // State and output registers; reset abandons any frame and drops the held byte.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_bitcnt <= 3'd0;
         r_shift  <= 8'd0;
         r_hold   <= 8'd0;
         r_full   <= 1'b0;
         r_silent <= 1'b1;
         r_low    <= 1'b0;
         r_bit    <= 1'b1;
         r_tape   <= 1'b0;
         r_busy   <= 1'b0;
         r_cnt    <= {CW{1'b0}};
         r_sent   <= 16'd0;
      end else begin
         r_state  <= w_state_n;
         r_bitcnt <= w_bitcnt_n;
         r_shift  <= w_shift_n;
         r_hold   <= w_hold_n;
         r_full   <= w_full_n;
         r_silent <= w_silent_n;
         r_low    <= w_low_n;
         r_bit    <= w_bit_n;
         r_tape   <= w_tape_n;
         r_busy   <= w_busy_n;
         r_cnt    <= w_cnt_n;
         r_sent   <= w_sent_n;
      end
   end

endmodule
